// File: rtl/any1_pkg.sv
// Shared types and size codes for the ANY-1 memory alignment path.
package any1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // log2 byte-count size codes
  localparam logic [2:0] SZ_BYTE   = 3'd0;
  localparam logic [2:0] SZ_WYDE   = 3'd1;
  localparam logic [2:0] SZ_TETRA  = 3'd2;
  localparam logic [2:0] SZ_OCTA   = 3'd3;
  localparam logic [2:0] SZ_HEXI   = 3'd4;
  localparam logic [2:0] SZ_BUS32  = 3'd5;
  localparam logic [2:0] SZ_BUS64  = 3'd6;

  // An access may not be wider than the bus.
  function automatic logic size_legal(input logic [2:0] size, input int unsigned ofs);
    return 32'(size) <= ofs;
  endfunction

endpackage

// File: rtl/any1_lane_gen.sv
// Combinational lane-select and write-data positioning across a two-beat window.
module any1_lane_gen
  import any1_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 32
) (
  input  logic [2:0]                   size,
  input  logic [$clog2(BUS_BYTES)-1:0] off,
  input  logic [BUS_BYTES*8-1:0]       dat,
  output logic [2*BUS_BYTES-1:0]       mask_c,
  output logic [2*BUS_BYTES*8-1:0]     dat_c,
  output logic                         need_b1_c
);

  localparam int unsigned OFS = $clog2(BUS_BYTES);
  localparam int unsigned MW  = 2 * BUS_BYTES;
  localparam int unsigned DW2 = 2 * BUS_BYTES * 8;

  logic [7:0]    nbytes;
  logic [MW-1:0] base;

  always_comb begin
    nbytes = 8'(1) << size;
    base   = '0;
    if (size_legal(size, OFS)) begin
      base = (MW'(1) << nbytes) - MW'(1);
    end
    mask_c    = base << off;
    dat_c     = DW2'(dat) << {off, 3'b000};
    need_b1_c = |mask_c[MW-1:BUS_BYTES];
  end

endmodule

// File: rtl/any1_mem_align.sv
// Load/store aligner: splits bus-crossing accesses into two beats and
// right-justifies returned load data.
module any1_mem_align
  import any1_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 32,
  parameter int unsigned AW        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_v,
  output logic                   req_rdy,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_adr,
  input  logic [2:0]             req_size,
  input  logic [BUS_BYTES*8-1:0] req_dat,
  output logic                   bus_v,
  output logic                   bus_we,
  output logic [AW-1:0]          bus_adr,
  output logic [BUS_BYTES-1:0]   bus_sel,
  output logic [BUS_BYTES*8-1:0] bus_dat_o,
  input  logic                   bus_ack,
  input  logic [BUS_BYTES*8-1:0] bus_dat_i,
  output logic                   resp_v,
  output logic                   resp_err,
  output logic [BUS_BYTES*8-1:0] resp_dat
);

  localparam int unsigned DW  = BUS_BYTES * 8;
  localparam int unsigned OFS = $clog2(BUS_BYTES);

  state_e               state_q, state_d;
  logic                 req_rdy_q, req_rdy_d;
  logic                 bus_v_q, bus_v_d;
  logic                 bus_we_q, bus_we_d;
  logic [AW-1:0]        bus_adr_q, bus_adr_d;
  logic [BUS_BYTES-1:0] bus_sel_q, bus_sel_d;
  logic [DW-1:0]        bus_dat_o_q, bus_dat_o_d;
  logic                 resp_v_q, resp_v_d;
  logic                 resp_err_q, resp_err_d;
  logic [DW-1:0]        resp_dat_q, resp_dat_d;
  logic [AW-1:0]        b1_adr_q, b1_adr_d;
  logic [BUS_BYTES-1:0] b1_sel_q, b1_sel_d;
  logic [DW-1:0]        b1_dat_q, b1_dat_d;
  logic                 need_b1_q, need_b1_d;
  logic [OFS-1:0]       off_q, off_d;
  logic [2:0]           size_q, size_d;
  logic                 we_q, we_d;
  logic [DW-1:0]        lo_q, lo_d;

  logic [2*BUS_BYTES-1:0] lane_mask;
  logic [2*DW-1:0]        lane_dat;
  logic                   lane_need_b1;
  logic [AW-1:0]          b0_adr;

  logic [DW-1:0]   merge_lo, merge_hi, keep, merged;
  logic [2*DW-1:0] merge_w;
  logic [7:0]      nbytes;

  any1_lane_gen #(
    .BUS_BYTES (BUS_BYTES)
  ) u_lane_gen (
    .size      (req_size),
    .off       (req_adr[OFS-1:0]),
    .dat       (req_dat),
    .mask_c    (lane_mask),
    .dat_c     (lane_dat),
    .need_b1_c (lane_need_b1)
  );

  assign b0_adr = req_adr & ~AW'(BUS_BYTES - 1);

  // Right-justify the beat pair; the acking beat's data is taken straight from the bus.
  always_comb begin
    merge_lo = (state_q == ST_B0) ? bus_dat_i : lo_q;
    merge_hi = (state_q == ST_B1) ? bus_dat_i : '0;
    merge_w  = {merge_hi, merge_lo} >> {off_q, 3'b000};
    nbytes   = 8'(1) << size_q;
    keep     = '0;
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      keep[i*8 +: 8] = (i < 32'(nbytes)) ? 8'hFF : 8'h00;
    end
    merged = DW'(merge_w) & keep;
  end

  always_comb begin
    state_d     = state_q;
    bus_v_d     = bus_v_q;
    bus_we_d    = bus_we_q;
    bus_adr_d   = bus_adr_q;
    bus_sel_d   = bus_sel_q;
    bus_dat_o_d = bus_dat_o_q;
    resp_v_d    = 1'b0;
    resp_err_d  = 1'b0;
    resp_dat_d  = resp_dat_q;
    b1_adr_d    = b1_adr_q;
    b1_sel_d    = b1_sel_q;
    b1_dat_d    = b1_dat_q;
    need_b1_d   = need_b1_q;
    off_d       = off_q;
    size_d      = size_q;
    we_d        = we_q;
    lo_d        = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (req_v && req_rdy_q) begin
          off_d     = req_adr[OFS-1:0];
          size_d    = req_size;
          we_d      = req_we;
          need_b1_d = lane_need_b1;
          b1_adr_d  = b0_adr + AW'(BUS_BYTES);
          b1_sel_d  = lane_mask[2*BUS_BYTES-1:BUS_BYTES];
          b1_dat_d  = lane_dat[2*DW-1:DW];
          if (!size_legal(req_size, OFS)) begin
            state_d    = ST_ERR;
            resp_err_d = 1'b1;
          end else begin
            state_d     = ST_B0;
            bus_v_d     = 1'b1;
            bus_we_d    = req_we;
            bus_adr_d   = b0_adr;
            bus_sel_d   = lane_mask[BUS_BYTES-1:0];
            bus_dat_o_d = lane_dat[DW-1:0];
          end
        end
      end
      ST_B0, ST_B1: begin
        if (bus_ack) begin
          lo_d = merge_lo;
          if (state_q == ST_B0 && need_b1_q) begin
            state_d     = ST_B1;
            bus_adr_d   = b1_adr_q;
            bus_sel_d   = b1_sel_q;
            bus_dat_o_d = b1_dat_q;
          end else begin
            state_d     = ST_IDLE;
            bus_v_d     = 1'b0;
            bus_we_d    = 1'b0;
            bus_adr_d   = '0;
            bus_sel_d   = '0;
            bus_dat_o_d = '0;
            resp_v_d    = 1'b1;
            resp_dat_d  = we_q ? '0 : merged;
          end
        end
      end
      ST_ERR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_rdy_q   <= 1'b1;
      bus_v_q     <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_adr_q   <= '0;
      bus_sel_q   <= '0;
      bus_dat_o_q <= '0;
      resp_v_q    <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_dat_q  <= '0;
      b1_adr_q    <= '0;
      b1_sel_q    <= '0;
      b1_dat_q    <= '0;
      need_b1_q   <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_rdy_q   <= req_rdy_d;
      bus_v_q     <= bus_v_d;
      bus_we_q    <= bus_we_d;
      bus_adr_q   <= bus_adr_d;
      bus_sel_q   <= bus_sel_d;
      bus_dat_o_q <= bus_dat_o_d;
      resp_v_q    <= resp_v_d;
      resp_err_q  <= resp_err_d;
      resp_dat_q  <= resp_dat_d;
      b1_adr_q    <= b1_adr_d;
      b1_sel_q    <= b1_sel_d;
      b1_dat_q    <= b1_dat_d;
      need_b1_q   <= need_b1_d;
      off_q       <= off_d;
      size_q      <= size_d;
      we_q        <= we_d;
      lo_q        <= lo_d;
    end
  end

  assign req_rdy   = req_rdy_q;
  assign bus_v     = bus_v_q;
  assign bus_we    = bus_we_q;
  assign bus_adr   = bus_adr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_dat_o = bus_dat_o_q;
  assign resp_v    = resp_v_q;
  assign resp_err  = resp_err_q;
  assign resp_dat  = resp_dat_q;

endmodule

// File: doc/any1_mem_align.md
Name: any1_mem_align

Overview:
- Parametrised successor to the combinational byte-select generator in the ANY-1 load/store path.
- Takes one load or store request with byte address and log2 size.
- Generates lane selects and shifted write data, and splits an access that crosses a bus-width boundary into two bus beats.
- For loads, merges the returned beats into right-justified data.
- Sits between the memory-stage request logic and the data-cache/bus interface.

Parameters:
- BUS_BYTES, 32, data bus width in bytes; power of 2, 4..64.
- AW, 32, address width.
- DW, BUS_BYTES*8, derived data width; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_v  in  1  request valid
- req_rdy  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_adr  in  AW  byte address
- req_size  in  3  log2 of byte count
- req_dat  in  DW  store data, right-justified
- bus_v  out  1  bus beat valid
- bus_we  out  1  bus write
- bus_adr  out  AW  beat address, aligned to BUS_BYTES
- bus_sel  out  BUS_BYTES  byte lane enables
- bus_dat_o  out  DW  lane-positioned write data
- bus_ack  in  1  beat complete; bus_dat_i valid on loads
- bus_dat_i  in  DW  read data
- resp_v  out  1  one-cycle completion pulse
- resp_err  out  1  one-cycle illegal-size pulse
- resp_dat  out  DW  right-justified load data, bytes beyond size zero

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state IDLE; req_rdy=1; bus_v=0; resp_v=0; resp_err=0; bus_adr, bus_sel, bus_dat_o, resp_dat = 0.
- Reset mid-operation: any state goes to IDLE on the next edge. bus_v drops, no resp_v is issued, and a pending beat is abandoned.
- Accept: req_rdy = (state==IDLE); a request is taken on an edge with req_v & req_rdy. All request fields are registered on accept.
- Geometry: OFS = log2(BUS_BYTES) bits; off = adr[OFS-1:0]; nbytes = 1<<size.
  - m2 = ((1<<nbytes)-1) << off, in 2*BUS_BYTES bits; d2 = req_dat << (off*8), in 2*DW bits.
  - Beat0: sel=m2 low half, dat=d2 low half, adr = adr with low OFS bits cleared.
  - Beat1 is needed iff m2 high half != 0. Its sel and dat are the high halves; adr = beat0 adr + BUS_BYTES, modulo 2^AW.
- Illegal size (size > log2(BUS_BYTES)): no bus beat; state ERR for one cycle; resp_err=1 in that cycle; then IDLE.
- State machine: IDLE -> B0 on accept (legal size) | ERR (illegal size).
  - B0: bus_v=1 with beat0 fields. On bus_ack: -> B1 if a second beat is needed, else -> IDLE with resp_v.
  - B1: bus_v=1 with beat1 fields. On bus_ack: -> IDLE with resp_v.
- Latency:
  - bus_v rises the cycle after accept.
  - resp_v is high the cycle after the final ack, the same cycle req_rdy is high again. Back-to-back requests are accepted in that cycle.
  - An ack in the same cycle bus_v first rises is legal. Minimum total is 2 cycles for one beat, 3 for two beats.
- bus_v stays high across the B0->B1 transition; fields change on the ack edge.
- Load merge: bus_dat_i is captured at the beat0 ack into low half and at the beat1 ack into high half (zero if no beat1).
  - resp_dat = ({hi,lo} >> off*8) truncated to DW, with bytes >= nbytes zeroed. Stable from resp_v until the next accept.
- Stores: resp_dat = 0.
- bus_ack while bus_v=0 is ignored.

Decomposition:
- any1_pkg: state enum (IDLE,B0,B1,ERR) and the size-code constants (BYTE..OCTA/BUS).
- Sub-module any1_lane_gen (combinational): size, offset, data -> 2*BUS_BYTES mask, 2*DW shifted data, need_b1 flag. It is reused by the future instruction-fetch aligner.

Test Plan (BUS_BYTES=32):
- Aligned store: adr=0x100, size=3 -> one beat; bus_adr=0x100, bus_sel=0x000000FF; resp_v 2 cycles after accept with zero-wait ack.
- Crossing store: adr=0x11E, size=2, dat=0xAABBCCDD -> beat0 adr 0x100, sel 0xC0000000, lanes 30-31 = DD,CC; beat1 adr 0x120, sel 0x00000003, lanes 0-1 = BB,AA.
- Crossing load: adr=0x13C, size=3; beat0 bus_dat_i lanes 28-31 = 11,22,33,44; beat1 lanes 0-3 = 55,66,77,88 -> resp_dat = 0x8877665544332211, upper bytes 0.
- Wrap: adr=0xFFFFFFFF, size=1 -> beat0 adr 0xFFFFFFE0, sel 0x80000000; beat1 adr 0x00000000, sel 0x00000001.
- Illegal size 6 -> no bus_v; resp_err pulses 1 cycle after accept; req_rdy returns the following cycle.
- rst asserted during B1 before ack -> next cycle bus_v=0, req_rdy=1, no resp_v. A later ack is ignored; a new request completes normally.
